// File: rtl/mtr_drv_if.sv
// ----------------------------------------------------------------------------
// mtr_drv_if
//   Bundles the motor driver's command inputs and gate-drive outputs.
//
//   Signals
//     duty            11  requested high-side duty, 0..2047 out of 2048
//     selGrn/Ylw/Blu   2  phase drive: 00 HIGHZ, 01 REVERSE, 10 FORWARD, 11 REGEN
//     high*/low*       1  FET gate enables per phase
//     PWM_synch        1  one-clk strobe at the PWM period boundary
//
//   Modports
//     master  command source (drives duty/sel, observes gates and strobe)
//     slave   the driver itself (mtr_drv)
// ----------------------------------------------------------------------------
interface mtr_drv_if;
    logic [10:0] duty;
    logic [1:0]  selGrn;
    logic [1:0]  selYlw;
    logic [1:0]  selBlu;
    logic        highGrn;
    logic        lowGrn;
    logic        highYlw;
    logic        lowYlw;
    logic        highBlu;
    logic        lowBlu;
    logic        PWM_synch;

    modport master (
        output duty, selGrn, selYlw, selBlu,
        input  highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, PWM_synch
    );

    modport slave (
        input  duty, selGrn, selYlw, selBlu,
        output highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, PWM_synch
    );
endinterface

// File: rtl/mtr_drv.sv
// ----------------------------------------------------------------------------
// mtr_drv
//   Three-phase motor gate driver. An 11-bit free-running counter defines a
//   2048-clk PWM period; the duty request is sampled once per period. Each
//   phase maps its drive select plus the PWM level to a desired (high,low)
//   gate pair, and a per-phase dead-time FSM guarantees both gates are off
//   for DEAD_TIME clks around every pair change. Pulses shorter than the
//   dead time never reach the gates.
//
//   Parameters
//     DEAD_TIME   non-overlap clks per pair change, legal 2..63
//
//   Ports
//     clk         system clock, rising edge
//     rst_n       asynchronous active-low reset
//     bus         mtr_drv_if.slave: duty, sel*, high*/low*, PWM_synch
//
//   Configuration
//     MTR_DRV_DUTY_CLAMP_EN  when defined, duty is clamped to 11'h7C0 so the
//                            low side gets at least 64 clks/period of
//                            desired on-time for bootstrap refresh.
// ----------------------------------------------------------------------------

// Per-phase dead-time controller.
//   clk, rst_n  clock / async active-low reset
//   sel         phase drive select
//   pwm         registered PWM level shared by all phases
//   high, low   registered gate enables for this phase
module mtr_drv_phase #(
    parameter int DEAD_TIME = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel,
    input  logic       pwm,
    output logic       high,
    output logic       low
);
    localparam logic [0:0] ST_DRIVE = 1'b0;
    localparam logic [0:0] ST_DEAD  = 1'b1;
    localparam logic [5:0] DEAD_LAST = 6'(DEAD_TIME - 1);

    logic [0:0] state;
    logic [1:0] des;      // desired {high,low} this clk
    logic [1:0] applied;  // pair currently allowed on the gates
    logic [1:0] pend;     // pair waiting out its dead interval
    logic [5:0] dcnt;

    always_comb begin
        des = 2'b00;
        case (sel)
            2'b01:   des = {~pwm, pwm};   // REVERSE
            2'b10:   des = {pwm, ~pwm};   // FORWARD
            2'b11:   des = {1'b0, pwm};   // REGEN
            default: des = 2'b00;         // HIGHZ
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_DRIVE;
            applied <= 2'b00;
            pend    <= 2'b00;
            dcnt    <= 6'd0;
            high    <= 1'b0;
            low     <= 1'b0;
        end else begin
            case (state)
                ST_DRIVE: begin
                    if (des != applied) begin
                        state <= ST_DEAD;
                        pend  <= des;
                        dcnt  <= 6'd0;
                        high  <= 1'b0;
                        low   <= 1'b0;
                    end else begin
                        high  <= des[1];
                        low   <= des[0];
                    end
                end
                default: begin
                    high <= 1'b0;
                    low  <= 1'b0;
                    if (des != pend) begin
                        // Any change restarts the full dead interval, which is
                        // what suppresses pulses shorter than DEAD_TIME.
                        pend <= des;
                        dcnt <= 6'd0;
                    end else if (dcnt == DEAD_LAST) begin
                        state   <= ST_DRIVE;
                        applied <= pend;
                        high    <= pend[1];
                        low     <= pend[0];
                    end else begin
                        dcnt <= dcnt + 6'd1;
                    end
                end
            endcase
        end
    end
endmodule

module mtr_drv #(
    parameter int DEAD_TIME = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    mtr_drv_if.slave bus
);
    logic [10:0] cnt;
    logic [10:0] duty_q;
    logic [10:0] duty_eff;
    logic        pwm;
    logic        synch;
    logic [2:0]  high;
    logic [2:0]  low;
    logic [2:0][1:0] sel;

`ifdef MTR_DRV_DUTY_CLAMP_EN
    assign duty_eff = (bus.duty > 11'h7C0) ? 11'h7C0 : bus.duty;
`else
    assign duty_eff = bus.duty;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 11'd0;
            duty_q <= 11'd0;
            pwm    <= 1'b0;
            synch  <= 1'b0;
        end else begin
            cnt   <= cnt + 11'd1;
            // Registered strobe: high during the clk where cnt==7FF.
            synch <= (cnt == 11'h7FE);
            pwm   <= (cnt < duty_q);
            // Duty only takes effect on a period boundary.
            if (cnt == 11'h7FF)
                duty_q <= duty_eff;
        end
    end

    assign sel = {bus.selBlu, bus.selYlw, bus.selGrn};

    for (genvar p = 0; p < 3; p++) begin : g_phase
        mtr_drv_phase #(.DEAD_TIME(DEAD_TIME)) u_phase (
            .clk   (clk),
            .rst_n (rst_n),
            .sel   (sel[p]),
            .pwm   (pwm),
            .high  (high[p]),
            .low   (low[p])
        );
    end

    assign bus.highGrn   = high[0];
    assign bus.lowGrn    = low[0];
    assign bus.highYlw   = high[1];
    assign bus.lowYlw    = low[1];
    assign bus.highBlu   = high[2];
    assign bus.lowBlu    = low[2];
    assign bus.PWM_synch = synch;
endmodule

// File: tb/tb_mtr_drv.sv
module tb_mtr_drv;
    localparam int DT = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mtr_drv_if bus ();
    mtr_drv #(.DEAD_TIME(DT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A gate pair reaches the outputs only once the desired pair has been
    // stable for more than DT consecutive clks; otherwise both gates are off.
    int         cnt_m, dq_m;
    bit         pwm_m, syn_m;
    int         run_m [3];
    bit [1:0]   prev_m[3];
    bit [1:0]   out_m [3];
    int         stepno, first_syn;
    int         hi_n[3], lo_n[3];

    function automatic bit [1:0] want(input bit [1:0] s, input bit p);
        case (s)
            2'b01:   return {~p, p};
            2'b10:   return {p, ~p};
            2'b11:   return {1'b0, p};
            default: return 2'b00;
        endcase
    endfunction

    function automatic int eff_duty(input int d);
`ifdef MTR_DRV_DUTY_CLAMP_EN
        return (d > 'h7C0) ? 'h7C0 : d;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        cnt_m = 0; dq_m = 0; pwm_m = 0; syn_m = 0;
        for (int p = 0; p < 3; p++) begin
            run_m[p] = 0; prev_m[p] = 0; out_m[p] = 0;
        end
    endtask

    task automatic model_edge();
        bit [1:0] s[3];
        bit [1:0] d;
        bit       pwm_n;
        s[0] = bus.selGrn; s[1] = bus.selYlw; s[2] = bus.selBlu;
        for (int p = 0; p < 3; p++) begin
            d = want(s[p], pwm_m);
            if (run_m[p] > 0 && d == prev_m[p]) begin
                if (run_m[p] < 100000) run_m[p]++;
            end else run_m[p] = 1;
            prev_m[p] = d;
            out_m[p] = (run_m[p] > DT) ? d : 2'b00;
        end
        pwm_n = (cnt_m < dq_m);
        syn_m = (cnt_m == 2046);
        if (cnt_m == 2047) dq_m = eff_duty(int'(bus.duty));
        pwm_m = pwm_n;
        cnt_m = (cnt_m + 1) % 2048;
    endtask

    function automatic logic [6:0] observed();
        return {bus.PWM_synch, bus.highGrn, bus.lowGrn, bus.highYlw, bus.lowYlw,
                bus.highBlu, bus.lowBlu};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        stepno++;
        chk("gates", 32'(observed()), 32'({syn_m, out_m[0], out_m[1], out_m[2]}));
        if (bus.PWM_synch === 1'b1 && first_syn < 0) first_syn = stepno;
        hi_n[0] += int'(bus.highGrn); lo_n[0] += int'(bus.lowGrn);
        hi_n[1] += int'(bus.highYlw); lo_n[1] += int'(bus.lowYlw);
        hi_n[2] += int'(bus.highBlu); lo_n[2] += int'(bus.lowBlu);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_counts();
        for (int p = 0; p < 3; p++) begin hi_n[p] = 0; lo_n[p] = 0; end
    endtask

    task automatic set_in(input int d, input bit [1:0] g, input bit [1:0] y, input bit [1:0] b);
        bus.duty = 11'(d); bus.selGrn = g; bus.selYlw = y; bus.selBlu = b;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_gates", 32'(observed()), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        stepno = 0;
        first_syn = -1;
    endtask

    initial begin
        set_in(0, 2'b00, 2'b00, 2'b00);
        model_reset();
        stepno = 0; first_syn = -1;
        clr_counts();
        #12;
        chk("por_gates", 32'(observed()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: all HIGHZ, strobe every 2048 clks starting at 2047.
        steps(2047);
        chk("first_synch", 32'(first_syn), 32'd2047);
        chk("idle_gates", 32'(hi_n[0] + lo_n[0] + hi_n[1] + lo_n[1] + hi_n[2] + lo_n[2]), 32'd0);
        steps(2048);

        // FORWARD on Grn, 50% duty.
        do_reset();
        set_in('h400, 2'b10, 2'b00, 2'b00);
        steps(2500);
        clr_counts();
        steps(2048);
        chk("fwd_high_cnt", 32'(hi_n[0]), 32'(1024 - DT));
        chk("fwd_low_cnt",  32'(lo_n[0]), 32'(1024 - DT));

        // Duty change mid-period, then REGEN on all phases.
        set_in('h200, 2'b10, 2'b00, 2'b00);
        steps(2048);
        set_in('h600, 2'b11, 2'b11, 2'b11);
        steps(3000);
        clr_counts();
        steps(2048);
        chk("regen_high", 32'(hi_n[0] + hi_n[1] + hi_n[2]), 32'd0);
        chk("regen_low",  32'(lo_n[1]), 32'(1536 - DT));

        // Ylw toggles inside the dead interval.
        set_in('h600, 2'b00, 2'b10, 2'b00);
        steps(10);
        set_in('h600, 2'b00, 2'b01, 2'b00);
        steps(10);
        set_in('h600, 2'b00, 2'b10, 2'b00);
        steps(60);

        // Full duty on Blu: the 1-clk low pulse is too short unless clamped.
        set_in('h7FF, 2'b00, 2'b00, 2'b10);
        steps(4200);
        clr_counts();
        steps(2048);
`ifdef MTR_DRV_DUTY_CLAMP_EN
        chk("blu_low_cnt",  32'(lo_n[2]), 32'd32);
        chk("blu_high_cnt", 32'(hi_n[2]), 32'(1984 - DT));
`else
        chk("blu_low_cnt",  32'(lo_n[2]), 32'd0);
        chk("blu_high_cnt", 32'(hi_n[2]), 32'(2048 - DT - 1));
`endif

        // Randomized segments, including short holds and occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            int d, hold;
            d = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 'h7FF : 0)
                                             : int'($urandom_range(0, 2047));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 600))
                                                : int'($urandom_range(1, 60));
            set_in(d, 2'($urandom), 2'($urandom), 2'($urandom));
            if ($urandom_range(0, 39) == 0) do_reset();
            steps(hold);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
